// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and memory.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_enable,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic              if_success,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {
    IDLE,
    MISS
  } state_e;

  state_e state_q, state_d;
  logic abort_q, abort_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic if_success_q, if_success_d;
  logic mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic hit;
  logic fill_we;
  logic hit_evt;
  logic miss_evt;
  logic unused_pc_lo;

  assign req_idx  = if_pc[INDEX_BITS+1:2];
  assign req_tag  = if_pc[ADDR_W-1:INDEX_BITS+2];
  // The pending line address lives in mem_addr_q for the whole miss.
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_pc_lo = ^if_pc[1:0];

  always_comb begin
    state_d      = state_q;
    abort_d      = abort_q;
    if_instr_d   = if_instr_q;
    if_success_d = if_success_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    valid_d      = valid_q;
    fill_we      = 1'b0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    if (rdy) begin
      if_success_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!flush && if_enable) begin
            if (hit) begin
              if_instr_d   = data_mem[req_idx];
              if_success_d = 1'b1;
              hit_evt      = 1'b1;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = {if_pc[ADDR_W-1:2], 2'b00};
              abort_d    = 1'b0;
              state_d    = MISS;
              miss_evt   = 1'b1;
            end
          end
        end
        MISS: begin
          if (flush) abort_d = 1'b1;
          if (mem_valid) begin
            fill_we           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            mem_req_d         = 1'b0;
            abort_d           = 1'b0;
            state_d           = IDLE;
            // A flushed fetch still fills the line but never delivers.
            if (!abort_q && !flush) begin
              if_instr_d   = mem_data;
              if_success_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      abort_q      <= 1'b0;
      if_instr_q   <= '0;
      if_success_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      abort_q      <= abort_d;
      if_instr_q   <= if_instr_d;
      if_success_q <= if_success_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_idx] <= mem_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  assign if_instr   = if_instr_q;
  assign if_success = if_success_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + 32'(hit_evt);
    miss_count_d = miss_count_q + 32'(miss_evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats;
  assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: vector table of fetches plus hand-written flush,
// stall and reset sequences; delivered words checked against a queue.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        if_enable;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_success;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.INDEX_BITS(8), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .if_enable  (if_enable),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_success (if_success),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [31:0] exp_q [$];

  bit mem_hold = 1'b0;
  bit busy = 1'b0;
  int cnt = 0;
  int req_count = 0;
  logic [31:0] req_addr = '0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s got=%h want=%h", n, a, e);
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    case (k)
      32'h0000_0010: return 32'h0050_0093;
      32'h0000_0020: return 32'hDEAD_BEEF;
      default:       return {k[15:0], ~k[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Memory model: answers a request three cycles after first seeing it.
  always @(negedge clk) begin
    if (rst) begin
      busy      = 1'b0;
      mem_valid = 1'b0;
    end else if (mem_valid) begin
      mem_valid = 1'b0;
    end else if (!mem_hold && mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        cnt = 2;
        req_count++;
        req_addr = mem_addr;
      end else begin
        chk("mem_addr_stable", mem_addr, req_addr);
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_word(mem_addr);
          busy      = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Scoreboard: every success must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && if_success) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_success got=%h want=none", if_instr);
      end else begin
        chk("success_instr", if_instr, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!mem_req && !mem_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("wait_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit miss);
    int r0;
    r0 = req_count;
    @(negedge clk);
    if_enable = 1'b1;
    if_pc = pc;
    exp_q.push_back(mem_word(pc));
    @(negedge clk);
    if_enable = 1'b0;
    chk("req_on_lookup", 32'(mem_req), 32'(miss));
    if (miss) chk("mem_addr", mem_addr, {pc[31:2], 2'b00});
    else chk("hit_latency", 32'(if_success), 32'd1);
    wait_idle();
    chk("req_count", 32'(req_count - r0), 32'(miss));
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          miss;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{32'h0000_0010, 1'b1};
    vecs[1]  = '{32'h0000_0010, 1'b0};
    vecs[2]  = '{32'h0000_0014, 1'b1};
    vecs[3]  = '{32'h0000_0014, 1'b0};
    vecs[4]  = '{32'h0000_0410, 1'b1};
    vecs[5]  = '{32'h0000_0010, 1'b1};
    vecs[6]  = '{32'h0000_0410, 1'b1};
    vecs[7]  = '{32'h0000_0010, 1'b1};
    vecs[8]  = '{32'h0000_0010, 1'b0};
    vecs[9]  = '{32'h0000_0800, 1'b1};
    vecs[10] = '{32'h0000_0803, 1'b0};
    vecs[11] = '{32'h0000_0014, 1'b0};

    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    if_enable = 1'b0;
    if_pc = '0;
    mem_valid = 1'b0;
    mem_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_success", 32'(if_success), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) fetch(vecs[i].pc, vecs[i].miss);

    // Flush one cycle into a miss: fill happens, delivery does not.
    @(negedge clk);
    if_enable = 1'b1;
    if_pc = 32'h0000_0020;
    @(negedge clk);
    if_enable = 1'b0;
    flush = 1'b1;
    chk("flush_miss_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    wait_idle();
    fetch(32'h0000_0020, 1'b0);

    // Flush in IDLE suppresses the lookup entirely.
    @(negedge clk);
    if_enable = 1'b1;
    if_pc = 32'h0000_0010;
    flush = 1'b1;
    @(negedge clk);
    if_enable = 1'b0;
    flush = 1'b0;
    chk("flush_idle_success", 32'(if_success), 32'd0);
    chk("flush_idle_req", 32'(mem_req), 32'd0);

    // rdy stall during a miss.
    mem_hold = 1'b1;
    exp_q.push_back(mem_word(32'h0000_1000));
    @(negedge clk);
    if_enable = 1'b1;
    if_pc = 32'h0000_1000;
    @(negedge clk);
    if_pc = 32'h0000_3000;
    chk("stall_req", 32'(mem_req), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_req", 32'(mem_req), 32'd1);
      chk("stall_mem_addr", mem_addr, 32'h0000_1000);
      chk("stall_success", 32'(if_success), 32'd0);
    end
    if_enable = 1'b0;
    rdy = 1'b1;
    mem_hold = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a miss.
    fetch(32'h0000_0010, 1'b0);
    mem_hold = 1'b1;
    @(negedge clk);
    if_enable = 1'b1;
    if_pc = 32'h0000_2010;
    @(negedge clk);
    if_enable = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_success", 32'(if_success), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    fetch(32'h0000_0010, 1'b1);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, 32'd0);
    chk("miss_count", miss_count, 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
